// File: rtl/bp_be_dep_tracker_if.sv
// Dispatch-side bundle for the BE dependency tracker: dispatch fields and kills in,
// per-stage dependency status and in-flight count out.
interface bp_be_dep_tracker_if #(
    parameter int reg_addr_width_p = 5,
    parameter int depth_p          = 5
);
    localparam int entry_width_lp = 9 + reg_addr_width_p;
    localparam int cnt_width_lp   = $clog2(depth_p + 1);

    logic                                dispatch_v_i;
    logic                                flush_i;
    logic [depth_p-1:0]                  kill_v_i;
    logic [reg_addr_width_p-1:0]         rd_addr_i;
    logic                                serial_v_i;
    logic                                mem_v_i;
    logic                                int_iwb_v_i;
    logic                                mul_iwb_v_i;
    logic                                mem_iwb_v_i;
    logic                                fp_iwb_v_i;
    logic                                mem_fwb_v_i;
    logic                                fp_fwb_v_i;
    logic [depth_p*entry_width_lp-1:0]   dep_status_o;
    logic [cnt_width_lp-1:0]             inflight_cnt_o;
    logic                                pipe_empty_o;

    modport master (
        output dispatch_v_i, flush_i, kill_v_i, rd_addr_i,
        output serial_v_i, mem_v_i,
        output int_iwb_v_i, mul_iwb_v_i, mem_iwb_v_i, fp_iwb_v_i,
        output mem_fwb_v_i, fp_fwb_v_i,
        input  dep_status_o, inflight_cnt_o, pipe_empty_o
    );

    modport slave (
        input  dispatch_v_i, flush_i, kill_v_i, rd_addr_i,
        input  serial_v_i, mem_v_i,
        input  int_iwb_v_i, mul_iwb_v_i, mem_iwb_v_i, fp_iwb_v_i,
        input  mem_fwb_v_i, fp_fwb_v_i,
        output dep_status_o, inflight_cnt_o, pipe_empty_o
    );
endinterface

// File: rtl/bp_be_dep_tracker.sv
// Shift-register record of in-flight BE instructions (rd + writeback class) that feeds
// the checker's hazard detector; kills and flushes zero entries so they stop hazarding.
module bp_be_dep_tracker #(
    parameter int reg_addr_width_p = 5,
    parameter int depth_p          = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    bp_be_dep_tracker_if.slave dep_if
);
    localparam int entry_width_lp = 9 + reg_addr_width_p;
    localparam int cnt_width_lp   = $clog2(depth_p + 1);

    logic [depth_p-1:0][entry_width_lp-1:0] slot_r, slot_n;
    logic [cnt_width_lp-1:0]                cnt_r, cnt_n, dec;
    logic                                   empty_r;
    logic                                   dispatch_ok;
    logic [depth_p-1:0]                     v_bits;

    assign dispatch_ok = dep_if.dispatch_v_i & ~dep_if.flush_i;

    // Slot 0 loads only on an unflushed dispatch; older slots shift unless killed.
    always_comb begin
        slot_n = '0;
        if (dispatch_ok) begin
            slot_n[0] = {dep_if.rd_addr_i,
                         dep_if.fp_fwb_v_i, dep_if.mem_fwb_v_i,
                         dep_if.fp_iwb_v_i, dep_if.mem_iwb_v_i,
                         dep_if.mul_iwb_v_i, dep_if.int_iwb_v_i,
                         dep_if.mem_v_i, dep_if.serial_v_i, 1'b1};
        end
        for (int i = 1; i < depth_p; i++) begin
            if (!(dep_if.flush_i || dep_if.kill_v_i[i-1])) begin
                slot_n[i] = slot_r[i-1];
            end
        end
    end

    // Killed valid entries and the unkilled tail retirement each leave the pipe once.
    always_comb begin
        dec = '0;
        for (int i = 0; i < depth_p; i++) begin
            dec = dec + cnt_width_lp'(slot_r[i][0] & dep_if.kill_v_i[i]);
        end
        dec = dec + cnt_width_lp'(slot_r[depth_p-1][0] & ~dep_if.kill_v_i[depth_p-1]);
        if (dep_if.flush_i) begin
            cnt_n = '0;
        end else begin
            cnt_n = cnt_r + cnt_width_lp'(dispatch_ok) - dec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot_r  <= '0;
            cnt_r   <= '0;
            empty_r <= 1'b1;
        end else begin
            slot_r  <= slot_n;
            cnt_r   <= cnt_n;
            empty_r <= (cnt_n == '0);
        end
    end

    assign dep_if.dep_status_o   = slot_r;
    assign dep_if.inflight_cnt_o = cnt_r;
    assign dep_if.pipe_empty_o   = empty_r;

    always_comb begin
        v_bits = '0;
        for (int i = 0; i < depth_p; i++) begin
            v_bits[i] = slot_r[i][0];
        end
    end

    function automatic logic [cnt_width_lp-1:0] popcount(input logic [depth_p-1:0] bits);
        logic [cnt_width_lp-1:0] total;
        total = '0;
        for (int i = 0; i < depth_p; i++) begin
            total = total + cnt_width_lp'(bits[i]);
        end
        return total;
    endfunction

    assert property (@(posedge clk_i) disable iff (reset_i)
        cnt_r == popcount(v_bits));

    assert property (@(posedge clk_i) disable iff (reset_i)
        !$isunknown({slot_r, cnt_r, empty_r}));
endmodule

// File: doc/bp_be_dep_tracker.md
Name: bp_be_dep_tracker

Overview:
- Records the destination register and writeback class of every instruction dispatched into the BE execution pipe.
- Shifts the record one slot per cycle, in lock-step with the calculator pipe.
- Drives the per-stage dependency status vector consumed by the checker's hazard detector.
- Sits between the dispatch decision (chk_dispatch_v) and the checker, and applies pipeline kills (exceptions, mispredict flush) so killed instructions stop causing hazards.

Parameters:
- reg_addr_width_p, 5, architectural register index width.
- depth_p, 5, number of tracked stages (slot 0 = EX1 … slot depth_p-1 = last writeback stage); must be ≥2.
- entry_width_lp (localparam), 9+reg_addr_width_p, packed entry width.
- cnt_width_lp (localparam), $clog2(depth_p+1), in-flight counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- dispatch_v_i  in  1  instruction accepted into EX1 this cycle.
- flush_i  in  1  kill all slots and any same-cycle dispatch.
- kill_v_i  in  depth_p  per-slot kill; bit i kills the entry currently in slot i.
- rd_addr_i  in  reg_addr_width_p  destination register of the dispatching instruction.
- serial_v_i, mem_v_i  in  1 each  serializing / memory instruction.
- int_iwb_v_i, mul_iwb_v_i, mem_iwb_v_i, fp_iwb_v_i  in  1 each  integer-RF write, by producing pipe.
- mem_fwb_v_i, fp_fwb_v_i  in  1 each  FP-RF write, by producing pipe.
- dep_status_o  out  depth_p*entry_width_lp  slot i at bits [i*entry_width_lp +: entry_width_lp].
- inflight_cnt_o  out  cnt_width_lp  count of valid slots (registered).
- pipe_empty_o  out  1  (inflight_cnt_o == 0), registered.

Behaviour:
- Entry layout, LSB first:
  - bit 0 v
  - bit 1 serial_v
  - bit 2 mem_v
  - bit 3 int_iwb_v
  - bit 4 mul_iwb_v
  - bit 5 mem_iwb_v
  - bit 6 fp_iwb_v
  - bit 7 mem_fwb_v
  - bit 8 fp_fwb_v
  - bits [9 +: reg_addr_width_p] rd_addr
- Reset (reset_i=1 at an edge): all slots all-zero, inflight_cnt_o=0, pipe_empty_o=1. Reset overrides dispatch, flush and kill in the same cycle.
- Slot 0 next value:
  - If dispatch_v_i & ~flush_i: the packed input fields with v=1.
  - Otherwise all-zero; flag inputs are ignored when not dispatching.
- Slot i (i≥1) next value:
  - If flush_i or kill_v_i[i-1]: all-zero.
  - Otherwise: slot i-1 unchanged.
- Killed entries are zeroed in full (every flag and rd_addr), not just v. Invariant: v=0 implies the whole entry is 0.
- Kill timing:
  - A kill takes effect on the next edge.
  - A killed entry is still visible in its current slot during the kill cycle.
  - kill_v_i[depth_p-1] only affects the retirement count; the entry falls off the end regardless.
- Shifting:
  - The pipe never stalls; every slot advances every cycle.
  - The entry in slot depth_p-1 is discarded at the next edge.
- rd_addr=0 entries are stored as given; x0 filtering belongs to the consumer.
- inflight_cnt_o next value (flush_i=0):
  - cnt + (dispatch_v_i) − (valid entries with kill_v_i set) − (slot depth_p-1 valid and not killed).
  - Equivalently, the popcount of the next-state v bits.
  - Saturation is impossible by construction.
- inflight_cnt_o next value (flush_i=1): (dispatch dropped) → 0.
- pipe_empty_o is updated in the same edge as inflight_cnt_o.
- Latency: dispatch at cycle N is visible in slot 0 at N+1 and in slot k at N+1+k, absent kills.
- Simultaneous events:
  - Dispatch with kill_v_i[0] kills the old slot-0 entry only; the new entry still loads.
  - flush_i dominates kill_v_i.
  - kill_v_i bits on invalid slots are harmless and do not decrement the count.
- Assertions (simulation):
  - inflight_cnt_o equals the popcount of the v bits in every cycle.
  - No X on outputs after reset.

Test Plan:
- Reset → all dep_status_o bits 0, inflight_cnt_o=0, pipe_empty_o=1. Then dispatch rd=7, mul_iwb → slot0 = {rd=7, bit4, bit0} = 0x0E11 one cycle later, slot1 one cycle after that, gone after 5 cycles.
- Back-to-back dispatch for 5 cycles (rd=1..5, int_iwb) → inflight_cnt_o ramps 1..5. Slot i holds rd=5−i. The 6th dispatch keeps the count at 5 as rd=1 retires.
- Pipe full (5 valid) with kill_v_i=5'b00110 → slots 2,3 all-zero next cycle, count 5→2 (slot-4 entry retires, plus 2 kills, +1 dispatch if issued).
- flush_i with dispatch_v_i=1 and kill_v_i=5'b11111 in the same cycle → every slot 0, count 0, pipe_empty_o=1 next cycle.
- dispatch_v_i=0 with all flag inputs driven to 1 and rd=31 → slot0 stays all-zero.
- reset_i asserted mid-stream with 3 valid entries and a concurrent dispatch → all-zero and count 0 next cycle. The first post-reset dispatch appears in slot 0 normally.
